// File: rtl/p_ftoi_if.sv
// rtl/p_ftoi_if.sv - operand/result bundle for the float-to-int pipeline
interface p_ftoi_if;
    logic        en;
    logic [31:0] in;
    logic [31:0] out;
    logic        valid;
    logic        overflow;
    logic        invalid;
    logic        inexact;

    // Producer side: drives the advance enable and the float operand.
    modport master (
        output en,
        output in,
        input  out,
        input  valid,
        input  overflow,
        input  invalid,
        input  inexact
    );

    // Converter side: consumes the operand, returns integer and flags.
    modport slave (
        input  en,
        input  in,
        output out,
        output valid,
        output overflow,
        output invalid,
        output inexact
    );
endinterface

// File: rtl/p_ftoi.sv
// rtl/p_ftoi.sv - 3-stage IEEE-754 single to int32 converter with flags
module p_ftoi #(
    parameter int ROUND_MODE = 0     // 0 = truncate toward zero, 1 = nearest, ties to even
) (
    input  logic    clk,
    input  logic    rst,
    p_ftoi_if.slave bus
);

    // Valid shift register: bit 0 = stage 1 holds a real item, bit 2 = output.
    logic [2:0]        valid_q, valid_d;

    // Stage 1: unpacked and classified operand.
    logic              s1_q, s1_d;
    logic signed [8:0] e1_q, e1_d;
    logic [23:0]       sig1_q, sig1_d;
    logic              nan1_q, nan1_d;
    logic              inf1_q, inf1_d;
    logic              big1_q, big1_d;
    logic              minv1_q, minv1_d;

    // Stage 2: aligned integer part plus guard/sticky.
    logic              s2_q, s2_d;
    logic [31:0]       int2_q, int2_d;
    logic              g2_q, g2_d;
    logic              st2_q, st2_d;
    logic              nan2_q, nan2_d;
    logic              inf2_q, inf2_d;
    logic              big2_q, big2_d;
    logic              minv2_q, minv2_d;

    // Stage 3: registered result and flags.
    logic [31:0]       out_q, out_d;
    logic              ovf_q, ovf_d;
    logic              inv_q, inv_d;
    logic              inx_q, inx_d;

    logic [7:0]        exp_in;
    logic [22:0]       man_in;
    logic [4:0]        shift_l;
    logic [54:0]       fx;
    logic              rnd_up;
    logic [31:0]       mag;
    logic [31:0]       res;

    assign exp_in = bus.in[30:23];
    assign man_in = bus.in[22:0];

    // Stage 1: split fields, unbias exponent, classify specials and range.
    always_comb begin
        s1_d    = bus.in[31];
        e1_d    = $signed({1'b0, exp_in}) - 9'sd127;
        sig1_d  = {(exp_in != 8'd0), man_in};
        nan1_d  = (exp_in == 8'hFF) && (man_in != 23'd0);
        inf1_d  = (exp_in == 8'hFF) && (man_in == 23'd0);
        big1_d  = (e1_d >= 9'sd31);
        // -2^31 is the only e=31 value that still fits in int32.
        minv1_d = bus.in[31] && (exp_in == 8'd158) && (man_in == 23'd0);
    end

    // Left shift amount; out-of-range values are handled by saturation later,
    // so their shift is forced to zero to keep the shifter narrow.
    assign shift_l = (big1_q || e1_q[8]) ? 5'd0 : e1_q[4:0];
    assign fx      = {31'd0, sig1_q} << shift_l;

    // Stage 2: align significand so bit 23 of fx is the units position.
    always_comb begin
        s2_d    = s1_q;
        nan2_d  = nan1_q;
        inf2_d  = inf1_q;
        big2_d  = big1_q;
        minv2_d = minv1_q;
        int2_d  = 32'd0;
        g2_d    = 1'b0;
        st2_d   = 1'b0;
        if (!e1_q[8]) begin
            int2_d = fx[54:23];
            g2_d   = fx[22];
            st2_d  = |fx[21:0];
        end else if (e1_q == -9'sd1) begin
            // Value in [0.5, 1): leading bit is exactly the half position.
            g2_d   = sig1_q[23];
            st2_d  = |sig1_q[22:0];
        end else begin
            // |value| < 0.5 (including denormals): everything is sticky.
            st2_d  = |sig1_q;
        end
    end

    // Rounding increment; never carries past 2^31 since the significand is 24 bits.
    assign rnd_up = (ROUND_MODE == 1) ? (g2_q & (st2_q | int2_q[0])) : 1'b0;
    assign mag    = int2_q + {31'd0, rnd_up};
    assign res    = s2_q ? (32'd0 - mag) : mag;

    // Stage 3: apply specials in priority order; empty slots produce zeros.
    always_comb begin
        out_d = 32'd0;
        ovf_d = 1'b0;
        inv_d = 1'b0;
        inx_d = 1'b0;
        if (valid_q[1]) begin
            if (nan2_q) begin
                inv_d = 1'b1;
            end else if (inf2_q || (big2_q && !minv2_q)) begin
                out_d = s2_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                ovf_d = 1'b1;
            end else if (minv2_q) begin
                out_d = 32'h8000_0000;
            end else begin
                out_d = res;
                inx_d = g2_q | st2_q;
            end
        end
    end

    // Valid pipe shifts in a 1 on every advancing edge.
    always_comb begin
        valid_d = {valid_q[1:0], 1'b1};
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            e1_q    <= 9'sd0;
            sig1_q  <= 24'd0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            big1_q  <= 1'b0;
            minv1_q <= 1'b0;
        end else if (bus.en) begin
            s1_q    <= s1_d;
            e1_q    <= e1_d;
            sig1_q  <= sig1_d;
            nan1_q  <= nan1_d;
            inf1_q  <= inf1_d;
            big1_q  <= big1_d;
            minv1_q <= minv1_d;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_q    <= 1'b0;
            int2_q  <= 32'd0;
            g2_q    <= 1'b0;
            st2_q   <= 1'b0;
            nan2_q  <= 1'b0;
            inf2_q  <= 1'b0;
            big2_q  <= 1'b0;
            minv2_q <= 1'b0;
        end else if (bus.en) begin
            s2_q    <= s2_d;
            int2_q  <= int2_d;
            g2_q    <= g2_d;
            st2_q   <= st2_d;
            nan2_q  <= nan2_d;
            inf2_q  <= inf2_d;
            big2_q  <= big2_d;
            minv2_q <= minv2_d;
        end
    end

    // Output register and valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 32'd0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            inx_q   <= 1'b0;
            valid_q <= 3'd0;
        end else if (bus.en) begin
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
            inx_q   <= inx_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.valid    = valid_q[2];
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;
    assign bus.inexact  = inx_q;

endmodule

// File: tb/tb_p_ftoi.sv
// tb/tb_p_ftoi.sv - scoreboard bench for p_ftoi, both rounding modes side by side
module tb_p_ftoi;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    p_ftoi_if bus0 ();
    p_ftoi_if bus1 ();

    p_ftoi #(.ROUND_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    p_ftoi #(.ROUND_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        int          tag;
        logic [31:0] in;
        logic [31:0] out;
        logic [2:0]  fl;     // {overflow, invalid, inexact}
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks   = 0;
    int failures = 0;
    int adv_cnt  = 0;

    logic [31:0] t_in [0:15] = '{32'h3FC00000, 32'h40200000, 32'hC2F6E979, 32'h42C80000,
                                 32'h4F000000, 32'hCF000000, 32'h4EFFFFFF, 32'h7FC00000,
                                 32'h7F800000, 32'hFF800000, 32'h00400000, 32'h80000000,
                                 32'h3F000000, 32'h3F400000, 32'hBFC00000, 32'h3F800000};
    logic [31:0] t_o0 [0:15] = '{32'd1, 32'd2, 32'hFFFFFF85, 32'd100,
                                 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80, 32'd0,
                                 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0,
                                 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1};
    logic [31:0] t_o1 [0:15] = '{32'd2, 32'd2, 32'hFFFFFF85, 32'd100,
                                 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80, 32'd0,
                                 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0,
                                 32'd0, 32'd1, 32'hFFFFFFFE, 32'd1};
    logic [2:0]  t_fl [0:15] = '{3'b001, 3'b001, 3'b001, 3'b000,
                                 3'b100, 3'b000, 3'b000, 3'b010,
                                 3'b100, 3'b100, 3'b001, 3'b000,
                                 3'b001, 3'b001, 3'b001, 3'b000};

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h expected=%h", name, k, got, exp);
        end
    endtask

    // Value-level reference: |x| = sig * 2^(E-150), then cut/round and range-check.
    function automatic void ref_model(input logic [31:0] f, input int rm,
                                      output logic [31:0] o, output logic [2:0] fl);
        longint sig, mag, rem, half;
        int     e_raw, r;
        bit     s, over;
        s = f[31];
        e_raw = int'(f[30:23]);
        over = 0; mag = 0; rem = 0; half = 0;
        if (e_raw == 255) begin
            if (f[22:0] != 23'd0) begin
                o = 32'd0; fl = 3'b010;
            end else begin
                o = s ? 32'h80000000 : 32'h7FFFFFFF; fl = 3'b100;
            end
            return;
        end
        sig = (e_raw != 0) ? ((64'sd1 <<< 23) | longint'(f[22:0])) : longint'(f[22:0]);
        if (e_raw >= 150) begin
            if (e_raw - 150 > 8) over = 1;
            else mag = sig <<< (e_raw - 150);
        end else begin
            r = 150 - e_raw;
            if (r >= 40) begin
                mag = 0; rem = sig; half = 64'sh7FFF_FFFF_FFFF_FFFF;
            end else begin
                mag  = sig >>> r;
                rem  = sig - (mag <<< r);
                half = 64'sd1 <<< (r - 1);
            end
            if (rm == 1 && (rem > half || (rem == half && mag[0]))) mag = mag + 1;
        end
        if (over || mag > (s ? 64'sd2147483648 : 64'sd2147483647)) begin
            o = s ? 32'h80000000 : 32'h7FFFFFFF; fl = 3'b100;
        end else begin
            o  = s ? 32'(-mag) : 32'(mag);
            fl = {2'b00, rem != 0};
        end
    endfunction

    function automatic logic [31:0] rnd_float();
        logic [31:0] v;
        logic [7:0]  ex;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: begin ex = 8'($urandom_range(118, 162)); v = {1'($urandom), ex, 23'($urandom)}; end
            2: begin ex = 8'($urandom_range(125, 150)); v = {1'($urandom), ex, 23'($urandom) & 23'h7F0000}; end
            default: begin
                case ($urandom_range(0, 3))
                    0: ex = 8'd0;
                    1: ex = 8'd255;
                    2: ex = 8'd158;
                    default: ex = 8'd157;
                endcase
                v = {1'($urandom), ex, ($urandom_range(0, 1) == 1) ? 23'($urandom) : 23'd0};
            end
        endcase
        return v;
    endfunction

    task automatic issue(input logic [31:0] v, input logic [31:0] o0, input logic [2:0] f0,
                         input logic [31:0] o1, input logic [2:0] f1);
        exp_t x;
        bus0.en = 1'b1; bus1.en = 1'b1;
        bus0.in = v;    bus1.in = v;
        x.tag = adv_cnt + 1;
        x.in  = v;
        x.out = o0; x.fl = f0; q0.push_back(x);
        x.out = o1; x.fl = f1; q1.push_back(x);
        @(negedge clk);
    endtask

    task automatic issue_model(input logic [31:0] v);
        logic [31:0] o0, o1;
        logic [2:0]  f0, f1;
        ref_model(v, 0, o0, f0);
        ref_model(v, 1, o1, f1);
        issue(v, o0, f0, o1, f1);
    endtask

    task automatic idle(input int n);
        bus0.en = 1'b0; bus1.en = 1'b0;
        bus0.in = $urandom; bus1.in = bus0.in;
        repeat (n) @(negedge clk);
    endtask

    task automatic mon(input int k, input logic [31:0] o, input logic v, input logic [2:0] fl);
        exp_t x;
        bit   have;
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (v) begin
            if (!have) begin
                chk("spurious_valid", k, 64'(v), 64'd0);
            end else begin
                if (k == 0) x = q0.pop_front();
                else        x = q1.pop_front();
                chk("latency", k, 64'(adv_cnt), 64'(x.tag + 2));
                chk("out",     k, 64'(o),       64'(x.out));
                chk("flags",   k, 64'(fl),      64'(x.fl));
            end
        end else begin
            chk("idle_zero", k, 64'({o, fl}), 64'd0);
            if (have) begin
                if (k == 0) x = q0[0];
                else        x = q1[0];
                if (x.tag + 2 <= adv_cnt) chk("missing_valid", k, 64'(v), 64'd1);
            end
        end
    endtask

    // Monitor: after each edge, check fresh results, reset state, or hold.
    initial begin
        logic        r_s, e_s;
        logic [35:0] cur0, cur1, last0, last1;
        last0 = '0; last1 = '0;
        forever begin
            @(posedge clk);
            r_s = rst;
            e_s = bus0.en;
            #1;
            cur0 = {bus0.out, bus0.valid, bus0.overflow, bus0.invalid, bus0.inexact};
            cur1 = {bus1.out, bus1.valid, bus1.overflow, bus1.invalid, bus1.inexact};
            if (r_s) begin
                adv_cnt = 0;
                chk("reset_state", 0, 64'(cur0), 64'd0);
                chk("reset_state", 1, 64'(cur1), 64'd0);
            end else if (e_s) begin
                adv_cnt++;
                mon(0, bus0.out, bus0.valid, {bus0.overflow, bus0.invalid, bus0.inexact});
                mon(1, bus1.out, bus1.valid, {bus1.overflow, bus1.invalid, bus1.inexact});
            end else begin
                chk("hold", 0, 64'(cur0), 64'(last0));
                chk("hold", 1, 64'(cur1), 64'(last1));
            end
            last0 = cur0;
            last1 = cur1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        bus0.en = 1'b0; bus1.en = 1'b0;
        bus0.in = 32'd0; bus1.in = 32'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) issue(t_in[i], t_o0[i], t_fl[i], t_o1[i], t_fl[i]);

        for (int i = 0; i < 3; i++) issue_model(rnd_float());
        idle(4);
        for (int i = 0; i < 3; i++) issue_model(rnd_float());

        for (int i = 0; i < 2; i++) issue_model(rnd_float());
        rst = 1'b1;
        bus0.en = 1'b1; bus1.en = 1'b1;
        q0.delete(); q1.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        for (int i = 0; i < 6; i++) issue_model(rnd_float());

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue_model(rnd_float());
        end

        issue_model(rnd_float());
        issue_model(rnd_float());
        chk("drain", 0, 64'(q0.size()), 64'd2);
        chk("drain", 1, 64'(q1.size()), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
